// File: rtl/adaptive_threshold_ctrl_if.sv
// rtl/adaptive_threshold_ctrl_if.sv - intensity pixel stream between pixel source and threshold controller
interface adaptive_threshold_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pixel;

  // Pixel producer side
  modport master (
    output in_valid,
    output in_pixel,
    input  in_ready
  );

  // Threshold controller side
  modport slave (
    input  in_valid,
    input  in_pixel,
    output in_ready
  );
endinterface

// File: rtl/adaptive_threshold_ctrl.sv
// rtl/adaptive_threshold_ctrl.sv - per-frame min/max tracking and threshold selection
module adaptive_threshold_ctrl #(
  parameter int WIDTH        = 8,
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int INIT_THR     = 128,
  parameter int MIN_CONTRAST = 16,
  parameter int XW           = 10,
  parameter int YW           = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 use_manual,
  input  logic [WIDTH-1:0]     manual_thr,
  adaptive_threshold_ctrl_if.slave in_s,
  output logic [WIDTH-1:0]     threshold,
  output logic                 thr_update,
  output logic                 flat_frame,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [XW-1:0]    X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST    = YW'(IMG_H - 1);
  localparam logic [WIDTH-1:0] THR_RESET = WIDTH'(INIT_THR);
  localparam logic [WIDTH:0]   MIN_SPAN  = (WIDTH+1)'(MIN_CONTRAST);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic             rdy;
  logic             accept;
  logic             last_pix;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   span;
  logic [WIDTH-1:0] mid;

  // Ready depends only on state so the source never sees a combinational loop through valid
  assign rdy          = (state == ACCUM);
  assign in_s.in_ready = rdy;
  assign accept       = in_s.in_valid && rdy;
  assign last_pix     = (x == X_LAST) && (y == Y_LAST);

  // One extra bit keeps min+max and max-min exact for full-scale pixels
  assign sum  = {1'b0, min_q} + {1'b0, max_q};
  assign span = {1'b0, max_q} - {1'b0, min_q};
  assign mid  = sum[WIDTH:1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the update strobe
  always_comb begin
    state_nxt  = state;
    thr_update = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (!enable)                  state_nxt = IDLE;
        else if (accept && last_pix)  state_nxt = UPDATE;
      end
      UPDATE: begin
        thr_update = 1'b1;
        state_nxt  = enable ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame statistics, raster position and end-of-frame threshold selection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q      <= '1;
      max_q      <= '0;
      x          <= '0;
      y          <= '0;
      threshold  <= THR_RESET;
      flat_frame <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (!enable) begin
            // Partial frame is abandoned; the pixel taken this cycle is dropped with it
            x     <= '0;
            y     <= '0;
            min_q <= '1;
            max_q <= '0;
          end else if (accept) begin
            if (in_s.in_pixel < min_q) min_q <= in_s.in_pixel;
            if (in_s.in_pixel > max_q) max_q <= in_s.in_pixel;
            if (x == X_LAST) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        UPDATE: begin
          if (use_manual) begin
            threshold  <= manual_thr;
            flat_frame <= 1'b0;
          end else if (span >= MIN_SPAN) begin
            threshold  <= mid;
            flat_frame <= 1'b0;
          end else begin
            flat_frame <= 1'b1;
          end
          frame_cnt <= frame_cnt + 16'd1;
          min_q     <= '1;
          max_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
